motoro3_multiphase_stepgen: RTL and testbench



---
 rtl/motoro3_pkg.sv | 27 ++
 rtl/motoro3_multiphase_stepgen_if.sv | 29 ++
 rtl/motoro3_ramp_unit.sv | 74 +++++++
 rtl/motoro3_multiphase_stepgen.sv | 137 +++++++++++++
 tb/tb_motoro3_multiphase_stepgen.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/motoro3_pkg.sv
// Shared types and index helpers for the multiphase step generator.
//   state_e      : run-state encoding (idle / run / stopping)
//   phase_offset : electrical offset of phase j, in steps
//   wrap_inc/dec : +1 / -1 modulo the number of steps per electrical cycle
package motoro3_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StRun      = 2'd1,
      StStopping = 2'd2
   } state_e;

   function automatic int unsigned phase_offset(input int unsigned j,
                                                input int unsigned nstep,
                                                input int unsigned nphase);
      return j * (nstep / nphase);
   endfunction

   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned nstep);
      return (v + 32'd1 >= nstep) ? 32'd0 : v + 32'd1;
   endfunction

   function automatic int unsigned wrap_dec(input int unsigned v, input int unsigned nstep);
      return (v == 32'd0) ? nstep - 32'd1 : v - 32'd1;
   endfunction

endpackage

// File: rtl/motoro3_multiphase_stepgen_if.sv
// Command/status bundle of the multiphase step generator.
//   master : drives m3start, m3freq, m3dir; observes the step outputs
//   slave  : the generator itself
//   m3step packs one STEPW-wide index per phase, phase 0 in the LSBs.
interface motoro3_multiphase_stepgen_if #(
   parameter int unsigned NPHASE = 3,
   parameter int unsigned STEPW  = 4,
   parameter int unsigned FREQW  = 10,
   parameter int unsigned CNTW   = 25
);
   logic                    m3start;
   logic [FREQW-1:0]        m3freq;
   logic                    m3dir;
   logic [NPHASE*STEPW-1:0] m3step;
   logic                    m3stepStb;
   logic [CNTW-1:0]         m3cnt;
   logic                    m3run;
   logic [FREQW-1:0]        m3curFreq;

   modport master (
      output m3start, m3freq, m3dir,
      input  m3step, m3stepStb, m3cnt, m3run, m3curFreq
   );

   modport slave (
      input  m3start, m3freq, m3dir,
      output m3step, m3stepStb, m3cnt, m3run, m3curFreq
   );
endinterface

// File: rtl/motoro3_ramp_unit.sv
// Linear frequency slewer with a RAMP_DIV-clock tick prescaler.
//   clk, nRst : clock, async active-low reset
//   target    : frequency to slew toward
//   enable    : 0 forces cur_freq and the prescaler to 0
//   load      : start of a run; cur_freq <- min(RAMP_INC, target), prescaler cleared
//   cur_freq  : current ramped frequency
// RAMP_INC = 0 disables ramping: cur_freq follows target every clock.
module motoro3_ramp_unit #(
   parameter int unsigned FREQW    = 10,
   parameter int unsigned RAMP_INC = 8,
   parameter int unsigned RAMP_DIV = 1000
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic [FREQW-1:0] target,
   input  logic             enable,
   input  logic             load,
   output logic [FREQW-1:0] cur_freq
);

   localparam int unsigned DivW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [FREQW:0] IncW = (FREQW + 1)'(RAMP_INC);

   if (RAMP_DIV < 1) begin : g_div_chk
      $error("RAMP_DIV must be at least 1");
   end
   if (RAMP_INC >= (1 << FREQW)) begin : g_inc_chk
      $error("RAMP_INC must fit in FREQW bits");
   end

   logic [DivW-1:0]  presc_q;
   logic             tick;
   logic [FREQW:0]   up_sum;
   logic [FREQW:0]   dn_diff;
   logic [FREQW-1:0] slew;
   logic [FREQW-1:0] load_val;

   assign tick = (presc_q == DivW'(RAMP_DIV - 1));

   // One increment toward target, clamped so it lands exactly and never wraps.
   always_comb begin
      up_sum  = {1'b0, cur_freq} + IncW;
      dn_diff = {1'b0, cur_freq} - IncW;
      slew    = cur_freq;
      if (target > cur_freq) begin
         slew = (up_sum > {1'b0, target}) ? target : up_sum[FREQW-1:0];
      end else if (target < cur_freq) begin
         slew = (dn_diff[FREQW] || (dn_diff[FREQW-1:0] < target)) ? target
                                                                  : dn_diff[FREQW-1:0];
      end
      load_val = ((RAMP_INC == 0) || ({1'b0, target} < IncW)) ? target : IncW[FREQW-1:0];
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         cur_freq <= '0;
         presc_q  <= '0;
      end else if (load) begin
         cur_freq <= load_val;
         presc_q  <= '0;
      end else if (!enable) begin
         cur_freq <= '0;
         presc_q  <= '0;
      end else if (RAMP_INC == 0) begin
         cur_freq <= target;
      end else if (tick) begin
         cur_freq <= slew;
         presc_q  <= '0;
      end else begin
         presc_q <= presc_q + DivW'(1);
      end
   end

endmodule

// File: rtl/motoro3_multiphase_stepgen.sv
// N-phase step-sequence generator with ramped phase-accumulator rate.
//   clk, nRst : 10 MHz system clock, async active-low reset
//   bus       : slave side of motoro3_multiphase_stepgen_if
//               m3start/m3freq/m3dir in; m3step, m3stepStb, m3cnt, m3run, m3curFreq out
// A step happens when acc + curFreq carries out of ACCW bits; the base index then
// moves +/-1 mod NSTEP and every phase index is base plus a fixed offset.
module motoro3_multiphase_stepgen
   import motoro3_pkg::*;
#(
   parameter int unsigned NPHASE   = 3,
   parameter int unsigned NSTEP    = 12,
   parameter int unsigned STEPW    = 4,
   parameter int unsigned FREQW    = 10,
   parameter int unsigned ACCW     = 16,
   parameter int unsigned CNTW     = 25,
   parameter int unsigned RAMP_INC = 8,
   parameter int unsigned RAMP_DIV = 1000
) (
   input logic                         clk,
   input logic                         nRst,
   motoro3_multiphase_stepgen_if.slave bus
);

   if (FREQW > ACCW) begin : g_freqw_chk
      $error("FREQW must not exceed ACCW");
   end
   if ((NPHASE < 1) || (NPHASE > 8) || ((NSTEP % NPHASE) != 0)) begin : g_phase_chk
      $error("NPHASE must be 1..8 and divide NSTEP");
   end
   if (NSTEP > (1 << STEPW)) begin : g_step_chk
      $error("NSTEP must fit in STEPW bits");
   end

   state_e                  state_q;
   logic [ACCW-1:0]         acc_q;
   logic [STEPW-1:0]        base_q;
   logic [NPHASE*STEPW-1:0] step_q;
   logic                    stb_q;
   logic [CNTW-1:0]         cnt_q;
   logic                    run_q;

   logic [FREQW-1:0]        cur_freq;
   logic [FREQW-1:0]        ramp_target;
   logic                    ramp_en;
   logic                    ramp_load;
   logic [ACCW:0]           acc_sum;
   logic                    carry;
   logic [STEPW-1:0]        base_next;
   logic [NPHASE*STEPW-1:0] step_next;

   // Target follows the next state: dropping m3start ramps toward 0 from that edge on.
   assign ramp_target = bus.m3start ? bus.m3freq : '0;
   assign ramp_en     = (state_q != StIdle);
   assign ramp_load   = (state_q == StIdle) && bus.m3start;

   motoro3_ramp_unit #(
      .FREQW    (FREQW),
      .RAMP_INC (RAMP_INC),
      .RAMP_DIV (RAMP_DIV)
   ) u_ramp (
      .clk      (clk),
      .nRst     (nRst),
      .target   (ramp_target),
      .enable   (ramp_en),
      .load     (ramp_load),
      .cur_freq (cur_freq)
   );

   // The add uses the registered (pre-tick) curFreq, so a coincident ramp tick
   // only affects the following clock.
   assign acc_sum = {1'b0, acc_q} + {{(ACCW + 1 - FREQW){1'b0}}, cur_freq};
   assign carry   = acc_sum[ACCW] && (state_q != StIdle);

   assign base_next = bus.m3dir ? STEPW'(wrap_inc(32'(base_q), NSTEP))
                                : STEPW'(wrap_dec(32'(base_q), NSTEP));

   always_comb begin
      step_next = '0;
      for (int unsigned j = 0; j < NPHASE; j++) begin
         step_next[j*STEPW +: STEPW] =
            STEPW'((32'(base_next) + phase_offset(j, NSTEP, NPHASE)) % NSTEP);
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= StIdle;
         acc_q   <= '0;
         base_q  <= '0;
         step_q  <= '0;
         stb_q   <= 1'b0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         stb_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               acc_q <= '0;
               if (bus.m3start) begin
                  state_q <= StRun;
                  cnt_q   <= '0;
                  run_q   <= 1'b1;
               end
            end
            StRun, StStopping: begin
               acc_q <= acc_sum[ACCW-1:0];
               if (carry) begin
                  base_q <= base_next;
                  step_q <= step_next;
                  stb_q  <= 1'b1;
                  cnt_q  <= cnt_q + CNTW'(1);
               end
               if (bus.m3start) begin
                  state_q <= StRun;
               end else if ((state_q == StStopping) && (cur_freq == '0)) begin
                  state_q <= StIdle;
                  acc_q   <= '0;
                  run_q   <= 1'b0;
               end else begin
                  state_q <= StStopping;
               end
            end
            default: begin
               state_q <= StIdle;
               run_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.m3step    = step_q;
   assign bus.m3stepStb = stb_q;
   assign bus.m3cnt     = cnt_q;
   assign bus.m3run     = run_q;
   assign bus.m3curFreq = cur_freq;

endmodule

// File: tb/tb_motoro3_multiphase_stepgen.sv
// Directed bench for motoro3_multiphase_stepgen.
//   dut_a : ACCW=4, FREQW=4, CNTW=3, no ramp -- stepping, direction, wrap, reset, fast stop
//   dut_b : ACCW=8, FREQW=8, RAMP_INC=8, RAMP_DIV=10 -- ramp up/down, restart while stopping
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_motoro3_multiphase_stepgen;

   logic clk;
   logic nRst;
   int   n_checks;
   int   n_errors;

   motoro3_multiphase_stepgen_if #(.NPHASE(3), .STEPW(4), .FREQW(4), .CNTW(3)) bus_a ();
   motoro3_multiphase_stepgen_if #(.NPHASE(3), .STEPW(4), .FREQW(8), .CNTW(8)) bus_b ();

   motoro3_multiphase_stepgen #(
      .NPHASE(3), .NSTEP(12), .STEPW(4), .FREQW(4), .ACCW(4), .CNTW(3),
      .RAMP_INC(0), .RAMP_DIV(1)
   ) dut_a (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus_a)
   );

   motoro3_multiphase_stepgen #(
      .NPHASE(3), .NSTEP(12), .STEPW(4), .FREQW(8), .ACCW(8), .CNTW(8),
      .RAMP_INC(8), .RAMP_DIV(10)
   ) dut_b (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected packed indices for base a: phases at +0, +4, +8 mod 12.
   function automatic logic [31:0] pack3(input int unsigned a);
      logic [11:0] v;
      v = {4'((a + 8) % 12), 4'((a + 4) % 12), 4'(a % 12)};
      return 32'(v);
   endfunction

   int unsigned dir_v [4] = '{0, 0, 1, 1};
   int unsigned a_v   [4] = '{11, 10, 11, 0};

   initial begin
      n_checks = 0;
      n_errors = 0;
      nRst = 1'b1;
      bus_a.m3start = 1'b0; bus_a.m3freq = '0; bus_a.m3dir = 1'b1;
      bus_b.m3start = 1'b0; bus_b.m3freq = '0; bus_b.m3dir = 1'b1;
      #1 nRst = 1'b0;
      #1;
      check_eq("rst_a_step", 32'(bus_a.m3step), 0);
      check_eq("rst_a_stb", 32'(bus_a.m3stepStb), 0);
      check_eq("rst_a_cnt", 32'(bus_a.m3cnt), 0);
      check_eq("rst_a_run", 32'(bus_a.m3run), 0);
      check_eq("rst_b_cur", 32'(bus_b.m3curFreq), 0);
      @(negedge clk);
      nRst = 1'b1;
      cyc(1);

      // Forward stepping at freq 4 with ACCW=4: one step every 4 clocks.
      bus_a.m3freq = 4'd4;
      bus_a.m3start = 1'b1;
      cyc(1);
      check_eq("a_run_start", 32'(bus_a.m3run), 1);
      check_eq("a_cur_start", 32'(bus_a.m3curFreq), 4);
      check_eq("a_step_hold", 32'(bus_a.m3step), 0);
      for (int k = 1; k <= 12; k++) begin
         cyc(3);
         check_eq("a_fwd_nostb", 32'(bus_a.m3stepStb), 0);
         cyc(1);
         check_eq("a_fwd_stb", 32'(bus_a.m3stepStb), 1);
         check_eq("a_fwd_step", 32'(bus_a.m3step), pack3(k % 12));
         check_eq("a_fwd_cnt", 32'(bus_a.m3cnt), 32'(k % 8));
      end

      // Reverse, then forward again, each change made mid-step.
      for (int i = 0; i < 4; i++) begin
         cyc(2);
         bus_a.m3dir = dir_v[i][0];
         cyc(1);
         check_eq("a_dir_nostb", 32'(bus_a.m3stepStb), 0);
         cyc(1);
         check_eq("a_dir_stb", 32'(bus_a.m3stepStb), 1);
         check_eq("a_dir_step", 32'(bus_a.m3step), pack3(a_v[i]));
         check_eq("a_dir_cnt", 32'(bus_a.m3cnt), 32'((13 + i) % 8));
      end

      // Async reset partway through a step.
      cyc(4);
      check_eq("a_pre_rst_cnt", 32'(bus_a.m3cnt), 1);
      cyc(1);
      #2 nRst = 1'b0;
      #1;
      check_eq("a_async_step", 32'(bus_a.m3step), 0);
      check_eq("a_async_cnt", 32'(bus_a.m3cnt), 0);
      check_eq("a_async_run", 32'(bus_a.m3run), 0);
      check_eq("a_async_cur", 32'(bus_a.m3curFreq), 0);
      bus_a.m3start = 1'b0;
      @(negedge clk);
      nRst = 1'b1;
      cyc(1);

      // No ramp: stop passes through STOPPING for a single clock.
      bus_a.m3start = 1'b1;
      cyc(1);
      check_eq("a_h0_cur", 32'(bus_a.m3curFreq), 4);
      bus_a.m3start = 1'b0;
      cyc(1);
      check_eq("a_h1_run", 32'(bus_a.m3run), 1);
      check_eq("a_h1_cur", 32'(bus_a.m3curFreq), 0);
      cyc(1);
      check_eq("a_h2_run", 32'(bus_a.m3run), 0);
      check_eq("a_h2_step", 32'(bus_a.m3step), 0);

      // Ramp up 8 -> 16 -> 20, ticks every 10 clocks from the start edge.
      bus_b.m3freq = 8'd20;
      bus_b.m3start = 1'b1;
      cyc(1);
      check_eq("b_f0_cur", 32'(bus_b.m3curFreq), 8);
      check_eq("b_f0_run", 32'(bus_b.m3run), 1);
      cyc(9);
      check_eq("b_f9_cur", 32'(bus_b.m3curFreq), 8);
      cyc(1);
      check_eq("b_f10_cur", 32'(bus_b.m3curFreq), 16);
      cyc(10);
      check_eq("b_f20_cur", 32'(bus_b.m3curFreq), 20);
      check_eq("b_f20_cnt", 32'(bus_b.m3cnt), 0);
      cyc(1);
      check_eq("b_f21_stb", 32'(bus_b.m3stepStb), 1);
      check_eq("b_f21_cnt", 32'(bus_b.m3cnt), 1);
      check_eq("b_f21_step", 32'(bus_b.m3step), pack3(1));
      cyc(4);

      // Ramp-down stop: 20 -> 12 -> 4 -> 0, then IDLE.
      bus_b.m3start = 1'b0;
      cyc(5);
      check_eq("b_f30_cur", 32'(bus_b.m3curFreq), 12);
      check_eq("b_f30_run", 32'(bus_b.m3run), 1);
      cyc(10);
      check_eq("b_f40_cur", 32'(bus_b.m3curFreq), 4);
      check_eq("b_f40_cnt", 32'(bus_b.m3cnt), 2);
      cyc(10);
      check_eq("b_f50_cur", 32'(bus_b.m3curFreq), 0);
      check_eq("b_f50_run", 32'(bus_b.m3run), 1);
      cyc(1);
      check_eq("b_f51_run", 32'(bus_b.m3run), 0);
      check_eq("b_f51_step", 32'(bus_b.m3step), pack3(2));
      cyc(5);
      check_eq("b_idle_step", 32'(bus_b.m3step), pack3(2));
      check_eq("b_idle_cnt", 32'(bus_b.m3cnt), 2);
      check_eq("b_idle_stb", 32'(bus_b.m3stepStb), 0);

      // Restart from IDLE clears m3cnt; restart from STOPPING keeps it.
      bus_b.m3start = 1'b1;
      cyc(1);
      check_eq("b_p0_cnt", 32'(bus_b.m3cnt), 0);
      cyc(21);
      check_eq("b_p21_step", 32'(bus_b.m3step), pack3(3));
      cyc(4);
      bus_b.m3start = 1'b0;
      cyc(5);
      check_eq("b_p30_cur", 32'(bus_b.m3curFreq), 12);
      cyc(2);
      bus_b.m3start = 1'b1;
      cyc(1);
      check_eq("b_p33_cur", 32'(bus_b.m3curFreq), 12);
      check_eq("b_p33_run", 32'(bus_b.m3run), 1);
      cyc(6);
      check_eq("b_p39_cur", 32'(bus_b.m3curFreq), 12);
      cyc(1);
      check_eq("b_p40_cur", 32'(bus_b.m3curFreq), 20);
      check_eq("b_p40_cnt", 32'(bus_b.m3cnt), 2);
      cyc(10);
      check_eq("b_p50_cur", 32'(bus_b.m3curFreq), 20);
      check_eq("b_p50_run", 32'(bus_b.m3run), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
